// File: rtl/conv_mac_seq_pkg.sv
// conv_pkg: shared FSM state, width and address helpers for conv_mac_seq.
// No ports; the build option CONV_SAT_EN is consumed by conv_mac_seq.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    FINAL,
    HOLD
  } conv_state_e;

  function automatic int conv_taps(input int k);
    return k * k;
  endfunction

  function automatic int conv_acc_w(input int k,
                                    input int dw,
                                    input int cw);
    return dw + cw + $clog2(k * k) + 1;
  endfunction

  function automatic int conv_bias_addr(input int k);
    return k * k;
  endfunction

endpackage

// File: rtl/conv_mac_seq_if.sv
// conv_mac_seq_if: window input and result output handshakes.
// master drives in_valid/in_win/shift/out_ready; slave drives the rest.
interface conv_mac_seq_if #(
  parameter int K       = 3,
  parameter int DATA_W  = 8,
  parameter int SHIFT_W = 5,
  parameter int OUT_W   = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [K*K*DATA_W-1:0] in_win;
  logic [SHIFT_W-1:0]    shift;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_data;

  modport master (
    output in_valid, in_win, shift, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_win, shift, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/conv_mac_seq_lane.sv
// conv_mac_lane: combinational LANES-wide multiply and sum.
// Ports: pix/wgt packed lane operands, en per-lane enable, sum partial sum.
module conv_mac_lane #(
  parameter int LANES  = 1,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic [LANES*DATA_W-1:0] pix,
  input  logic [LANES*COEF_W-1:0] wgt,
  input  logic [LANES-1:0]        en,
  output logic [ACC_W-1:0]        sum
);

  localparam int P_W = DATA_W + COEF_W;

  logic [P_W-1:0] prod;

  always_comb begin
    sum  = '0;
    prod = '0;
    for (int l = 0; l < LANES; l++) begin
      prod = P_W'(pix[l*DATA_W +: DATA_W])
           * P_W'(wgt[l*COEF_W +: COEF_W]);
      if (en[l]) sum = sum + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/conv_mac_seq.sv
// conv_mac_seq: sequential KxK MAC with bias, shift and requantise.
// Ports: clk, rst_n, bus (slave handshakes), w_we/w_addr/w_data, w_err.
// Build option: CONV_SAT_EN saturates out_data instead of wrapping.
module conv_mac_seq
  import conv_pkg::*;
#(
  parameter int K       = 3,
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 8,
  parameter int BIAS_W  = 8,
  parameter int OUT_W   = 8,
  parameter int LANES   = 1,
  parameter int SHIFT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  conv_mac_seq_if.slave bus,
  input  logic w_we,
  input  logic [$clog2(K*K+1)-1:0] w_addr,
  input  logic [((COEF_W > BIAS_W) ? COEF_W : BIAS_W)-1:0] w_data,
  output logic w_err
);

  localparam int TAPS  = conv_taps(K);
  localparam int ACC_W = conv_acc_w(K, DATA_W, COEF_W);
  localparam int N     = (TAPS + LANES - 1) / LANES;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int AW    = $clog2(TAPS + 1);

  localparam logic [AW-1:0] BIAS_A =
    AW'(conv_bias_addr(K));
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(N - 1);

  conv_state_e           state;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [OUT_W-1:0]      out_data_q;
  logic [ACC_W-1:0]      acc;
  logic [CNT_W-1:0]      cnt;
  logic [TAPS*DATA_W-1:0] win_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic [COEF_W-1:0]     wgt_q [TAPS];
  logic [BIAS_W-1:0]     bias_q;

  logic [LANES*DATA_W-1:0] lp;
  logic [LANES*COEF_W-1:0] lw;
  logic [LANES-1:0]        le;
  logic [ACC_W-1:0]        lane_sum;
  logic [ACC_W:0]          sum_b;
  logic [ACC_W:0]          res;
  logic                    accept;
  logic                    wr_ok;

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  assign accept = bus.in_valid && in_ready_q;
  // Kernel is frozen while a window is in flight or being accepted.
  assign wr_ok  = (state == IDLE) && !accept
               && (w_addr <= BIAS_A);

  always_comb begin : tap_sel
    int idx;
    lp  = '0;
    lw  = '0;
    le  = '0;
    idx = 0;
    for (int l = 0; l < LANES; l++) begin
      idx = int'(cnt) * LANES + l;
      if (idx < TAPS) begin
        le[l] = 1'b1;
        lp[l*DATA_W +: DATA_W] =
          win_q[idx*DATA_W +: DATA_W];
        lw[l*COEF_W +: COEF_W] = wgt_q[idx];
      end
    end
  end

  conv_mac_lane #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_lane (
    .pix (lp),
    .wgt (lw),
    .en  (le),
    .sum (lane_sum)
  );

  assign sum_b = {1'b0, acc} + (ACC_W+1)'(bias_q);
  assign res   = (int'(shift_q) >= ACC_W)
               ? '0 : (sum_b >> shift_q);

`ifdef CONV_SAT_EN
  localparam logic [ACC_W:0] OMAX =
    (ACC_W+1)'({OUT_W{1'b1}});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      w_err       <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      win_q       <= '0;
      shift_q     <= '0;
      bias_q      <= '0;
      for (int i = 0; i < TAPS; i++) wgt_q[i] <= '0;
    end else begin
      w_err <= 1'b0;
      if (w_we) begin
        if (!wr_ok) begin
          w_err <= 1'b1;
        end else if (w_addr == BIAS_A) begin
          bias_q <= w_data[BIAS_W-1:0];
        end else begin
          wgt_q[w_addr] <= w_data[COEF_W-1:0];
        end
      end
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            win_q      <= bus.in_win;
            shift_q    <= bus.shift;
            acc        <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= acc + lane_sum;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FINAL;
        end
        FINAL: begin
`ifdef CONV_SAT_EN
          out_data_q <= (res > OMAX)
                      ? {OUT_W{1'b1}} : res[OUT_W-1:0];
`else
          out_data_q <= res[OUT_W-1:0];
`endif
          out_valid_q <= 1'b1;
          state       <= HOLD;
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
